// File: rtl/itim_assoc.sv
// N-way set-associative instruction TIM. Lines refill one word per memory beat.
// Fetches outside [itim_base, itim_top) bypass the cache uncached.

package itim_assoc_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;

endpackage

module itim_assoc
    import itim_assoc_pkg::*;
#(
    parameter int          ways      = 2,
    parameter int          depth     = 6,
    parameter int          width     = 2,
    parameter logic [31:0] itim_base = 32'h0000_0000,
    parameter logic [31:0] itim_top  = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  itim_in,
    output mem_out_type itim_out,
    input  mem_out_type imem_out,
    output mem_in_type  imem_in
);

    localparam int                sets  = 2 ** depth;
    localparam int                words = 2 ** width;
    localparam int                tag_w = 32 - depth - width - 2;
    localparam int                rr_w  = (ways > 1) ? $clog2(ways) : 1;
    localparam logic [31:0]       span  = itim_top - itim_base;
    localparam logic [width-1:0]  last  = '1;

    typedef enum logic [1:0] {HIT, MISS, UPDATE, LOAD} state_t;

    state_t state_q, state_d;

    logic [tag_w-1:0]       tag_mem  [ways][sets];
    logic [words-1:0][31:0] data_mem [ways][sets];
    logic [tag_w-1:0]       tag_rd   [ways];
    logic [words-1:0][31:0] line_rd  [ways];

    logic [sets-1:0][ways-1:0] valid_q;
    logic [rr_w-1:0]           rr_q [sets];

    logic                   req_q;
    logic                   fence_q;
    logic [31:0]            addr_q;
    logic [rr_w-1:0]        victim_q;
    logic [width-1:0]       cnt_q;
    logic [words-1:0][31:0] buf_q;
    logic [words-1:0][31:0] fill_line;

    logic [tag_w-1:0] req_tag;
    logic [depth-1:0] req_set;
    logic [width-1:0] req_word;
    logic [depth-1:0] rd_set;
    logic [32:0]      offset;
    logic             in_window;
    logic             accept;

    logic            hit;
    logic [rr_w-1:0] hit_way;
    logic            has_free;
    logic [rr_w-1:0] free_way;

    logic fill_done;
    logic fence_clr;
    logic alloc;
    logic unused_ok;

    assign req_tag   = addr_q[31:depth+width+2];
    assign req_set   = addr_q[depth+width+1:width+2];
    assign req_word  = addr_q[width+1:2];
    assign rd_set    = (state_q == HIT) ? itim_in.mem_addr[depth+width+1:width+2] : req_set;
    assign offset    = {1'b0, addr_q} - {1'b0, itim_base};
    assign in_window = !offset[32] && (offset[31:0] < span);
    assign accept    = (state_q == HIT) && (state_d == HIT) && itim_in.mem_valid;
    assign unused_ok = ^{itim_in.mem_instr, itim_in.mem_wdata, itim_in.mem_wstrb};

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = ways - 1; w >= 0; w--) begin
            if (valid_q[req_set][w] && (tag_rd[w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = rr_w'(w);
            end
            if (!valid_q[req_set][w]) begin
                has_free = 1'b1;
                free_way = rr_w'(w);
            end
        end
    end

    always_comb begin
        fill_line         = buf_q;
        fill_line[cnt_q]  = imem_out.mem_rdata;
    end

    always_comb begin
        state_d           = state_q;
        itim_out          = '0;
        imem_in           = '0;
        imem_in.mem_instr = 1'b1;
        fill_done         = 1'b0;
        fence_clr         = 1'b0;
        alloc             = 1'b0;
        case (state_q)
            HIT: begin
                if (req_q) begin
                    if (fence_q) begin
                        fence_clr          = 1'b1;
                        itim_out.mem_ready = 1'b1;
                    end else if (!in_window) begin
                        state_d = LOAD;
                    end else if (hit) begin
                        itim_out.mem_ready = 1'b1;
                        itim_out.mem_rdata = line_rd[hit_way][req_word];
                    end else begin
                        state_d = MISS;
                        alloc   = 1'b1;
                    end
                end
            end
            MISS: begin
                imem_in.mem_valid = 1'b1;
                imem_in.mem_addr  = {addr_q[31:width+2], cnt_q, 2'b00};
                if (imem_out.mem_ready && (cnt_q == last)) begin
                    fill_done = 1'b1;
                    state_d   = UPDATE;
                end
            end
            UPDATE: begin
                itim_out.mem_ready = 1'b1;
                itim_out.mem_rdata = buf_q[req_word];
                state_d            = HIT;
            end
            LOAD: begin
                imem_in.mem_valid = 1'b1;
                imem_in.mem_addr  = addr_q;
                if (imem_out.mem_ready) begin
                    itim_out.mem_ready = 1'b1;
                    itim_out.mem_rdata = imem_out.mem_rdata;
                    state_d            = HIT;
                end
            end
            default: state_d = HIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= HIT;
            req_q    <= 1'b0;
            fence_q  <= 1'b0;
            addr_q   <= '0;
            victim_q <= '0;
            cnt_q    <= '0;
            buf_q    <= '0;
            valid_q  <= '0;
            for (int s = 0; s < sets; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            req_q   <= accept;
            if (accept) begin
                fence_q <= itim_in.mem_fence;
                addr_q  <= itim_in.mem_addr;
            end
            if (alloc) begin
                victim_q <= has_free ? free_way : rr_q[req_set];
                cnt_q    <= '0;
            end
            if ((state_q == MISS) && imem_out.mem_ready) begin
                buf_q[cnt_q] <= imem_out.mem_rdata;
                cnt_q        <= cnt_q + width'(1);
            end
            if (fill_done) begin
                valid_q[req_set][victim_q] <= 1'b1;
                rr_q[req_set] <= (rr_q[req_set] == rr_w'(ways - 1)) ? '0 : rr_q[req_set] + rr_w'(1);
            end
            if (fence_clr) begin
                valid_q <= '0;
            end
        end
    end

    // Tag/data arrays are plain synchronous RAMs; validity lives in valid_q.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[victim_q][req_set]  <= req_tag;
            data_mem[victim_q][req_set] <= fill_line;
        end
        for (int w = 0; w < ways; w++) begin
            tag_rd[w]  <= tag_mem[w][rd_set];
            line_rd[w] <= data_mem[w][rd_set];
        end
    end

endmodule

// File: tb/tb_itim_assoc.sv
// Directed bench for itim_assoc (2 ways, 4 sets, 4-word lines, window [0, 0x1000)).
// Memory words read back as 0xDEAD_0000 | addr[15:0].

module tb_itim_assoc;
    import itim_assoc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    mem_in_type  itim_in = '0;
    mem_out_type itim_out;
    mem_out_type imem_out = '0;
    mem_in_type  imem_in;

    int checks   = 0;
    int failures = 0;
    logic [31:0] beat_log[$];

    itim_assoc #(
        .ways(2), .depth(2), .width(2),
        .itim_base(32'h0000_0000), .itim_top(32'h0000_1000)
    ) dut (
        .clk(clk), .rst(rst),
        .itim_in(itim_in), .itim_out(itim_out),
        .imem_out(imem_out), .imem_in(imem_in)
    );

    always #5 clk = ~clk;

    // Memory model: answers a pending request one beat every other cycle.
    always @(posedge clk) begin
        #1;
        if (imem_in.mem_valid && !imem_out.mem_ready) begin
            imem_out.mem_ready = 1'b1;
            imem_out.mem_rdata = 32'hDEAD_0000 | {16'h0, imem_in.mem_addr[15:0]};
            beat_log.push_back(imem_in.mem_addr);
        end else begin
            imem_out.mem_ready = 1'b0;
            imem_out.mem_rdata = '0;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic fence,
                                  output logic [31:0] rdata, output int lat);
        beat_log.delete();
        @(posedge clk);
        #3;
        itim_in           = '0;
        itim_in.mem_valid = 1'b1;
        itim_in.mem_fence = fence;
        itim_in.mem_instr = 1'b1;
        itim_in.mem_addr  = addr;
        @(posedge clk);
        #2;
        itim_in.mem_valid = 1'b0;
        itim_in.mem_fence = 1'b0;
        lat   = 1;
        rdata = '0;
        while (!itim_out.mem_ready && lat < 40) begin
            @(posedge clk);
            #2;
            lat++;
        end
        if (itim_out.mem_ready) rdata = itim_out.mem_rdata;
        else check_output("ready_timeout", {31'b0, itim_out.mem_ready}, 32'd1);
    endtask

    task automatic fetch_check(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                               input int exp_beats, input int exp_lat);
        logic [31:0] rdata;
        int lat;
        apply_stimulus(addr, 1'b0, rdata, lat);
        check_output({tag, "_rdata"}, rdata, exp_data);
        check_output({tag, "_beats"}, 32'(beat_log.size()), 32'(exp_beats));
        check_output({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_first_beat(input string tag, input logic [31:0] exp_addr);
        if (beat_log.size() > 0) check_output(tag, beat_log[0], exp_addr);
        else check_output(tag, 32'hFFFF_FFFF, exp_addr);
    endtask

    initial begin
        logic [31:0] rdata;
        int lat;
        int n;

        repeat (3) @(posedge clk);
        #2;
        check_output("rst_itim_ready", {31'b0, itim_out.mem_ready}, 32'd0);
        check_output("rst_itim_rdata", itim_out.mem_rdata, 32'd0);
        check_output("rst_imem_valid", {31'b0, imem_in.mem_valid}, 32'd0);
        check_output("rst_imem_addr", imem_in.mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        apply_stimulus(32'h0, 1'b1, rdata, lat);
        check_output("fence_empty_lat", 32'(lat), 32'd1);
        check_output("fence_empty_rdata", rdata, 32'd0);

        fetch_check("cold0", 32'h0000, 32'hDEAD_0000, 4, 9);
        if (beat_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_output($sformatf("cold0_beat%0d", i), beat_log[i], 32'(4 * i));
            end
        end
        fetch_check("hit8", 32'h0008, 32'hDEAD_0008, 0, 1);

        fetch_check("fill40", 32'h0040, 32'hDEAD_0040, 4, 9);
        fetch_check("hit0", 32'h0000, 32'hDEAD_0000, 0, 1);
        fetch_check("hit44", 32'h0044, 32'hDEAD_0044, 0, 1);
        fetch_check("fill80", 32'h0080, 32'hDEAD_0080, 4, 9);
        fetch_check("still40", 32'h0040, 32'hDEAD_0040, 0, 1);
        fetch_check("evicted0", 32'h0000, 32'hDEAD_0000, 4, 9);
        fetch_check("hit8c", 32'h0088, 32'hDEAD_0088, 0, 1);

        fetch_check("bypass1", 32'h2000, 32'hDEAD_2000, 1, 2);
        check_first_beat("bypass1_addr", 32'h2000);
        fetch_check("bypass2", 32'h2000, 32'hDEAD_2000, 1, 2);

        fetch_check("fill10", 32'h0010, 32'hDEAD_0010, 4, 9);
        apply_stimulus(32'h0, 1'b1, rdata, lat);
        check_output("fence_lat", 32'(lat), 32'd1);
        check_output("fence_rdata", rdata, 32'd0);
        fetch_check("post_fence0", 32'h0004, 32'hDEAD_0004, 4, 9);
        check_first_beat("post_fence0_first", 32'h0000);
        fetch_check("post_fence10", 32'h0010, 32'hDEAD_0010, 4, 9);
        fetch_check("post_fence80", 32'h0080, 32'hDEAD_0080, 4, 9);

        // Reset asserted in the middle of a refill.
        beat_log.delete();
        @(posedge clk);
        #3;
        itim_in.mem_valid = 1'b1;
        itim_in.mem_addr  = 32'h0100;
        @(posedge clk);
        #2;
        itim_in.mem_valid = 1'b0;
        n = 0;
        while (beat_log.size() < 2 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_output("mid_beats", 32'(beat_log.size()), 32'd2);
        @(posedge clk);
        #3;
        check_output("pre_rst_valid", {31'b0, imem_in.mem_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check_output("rst_async_valid", {31'b0, imem_in.mem_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        fetch_check("after_rst", 32'h0100, 32'hDEAD_0100, 4, 9);
        check_first_beat("after_rst_first", 32'h0100);

        fetch_check("top_minus4", 32'h0FFC, 32'hDEAD_0FFC, 4, 9);
        check_first_beat("top_minus4_first", 32'h0FF0);
        fetch_check("top_minus4_hit", 32'h0FFC, 32'hDEAD_0FFC, 0, 1);
        fetch_check("at_top", 32'h1000, 32'hDEAD_1000, 1, 2);
        check_first_beat("at_top_addr", 32'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/itim_assoc.md
Name: itim_assoc

Overview:
Parametrised N-way set-associative instruction TIM/cache. It sits between the fetch stage (itim_in/itim_out) and the instruction memory bus (imem_in/imem_out). Lines are refilled one word per bus beat. Addresses outside [itim_base, itim_top) bypass the cache uncached. The fence operation invalidates the whole cache in one cycle.

Parameters:
ways, 2, number of ways per set (power of two, 1..8)
depth, 6, log2 number of sets
width, 2, log2 32-bit words per line
itim_base, 32'h0000_0000, first cacheable byte address
itim_top, 32'h0010_0000, first non-cacheable byte address above the window

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
itim_in  in  mem_in_type  fetch request (mem_valid, mem_fence, mem_instr, mem_addr[31:0]; mem_wdata/mem_wstrb ignored)
itim_out  out  mem_out_type  fetch response (mem_rdata[31:0], mem_ready)
imem_out  in  mem_out_type  memory response (mem_rdata[31:0], mem_ready)
imem_in  out  mem_in_type  memory request (mem_valid, mem_fence=0, mem_instr=1, mem_addr, mem_wdata=0, mem_wstrb=0)

Behaviour:
- Reset (rst=0, async): state=HIT; all valid bits=0; all RR pointers=0. Outputs itim_out.mem_ready=0, mem_rdata=0, imem_in.mem_valid=0, mem_addr=0.
- Address split: tag=addr[31:depth+width+2]; set=addr[depth+width+1:width+2]; word=addr[width+1:2].
- Storage: tag and data arrays per way, synchronous read with 1-cycle latency. The read address is the set of the incoming request, or of the held request while the block is busy. Valid bits are a flop vector (ways x 2**depth) so they can be async-cleared.
- Protocol: one outstanding request. The requester issues mem_valid for one cycle and must not issue again until it has seen mem_ready. Requests arriving while the state is not HIT are ignored.
- HIT state (lookup one cycle after the request):
  - fence -> clear every valid bit in the same cycle; mem_ready=1, rdata=0 on the next cycle.
  - address outside the window -> LOAD.
  - any way with valid and matching tag -> mem_ready=1, rdata=data[way][word] in the lookup cycle. Total latency is 1 cycle after the request.
  - more than one matching way is impossible by construction; the implementation picks the lowest index.
  - otherwise -> MISS. Victim = lowest invalid way, else the set's round-robin pointer. Line address has addr[width+1:0]=0; cnt=0.
- MISS: imem_in.mem_valid=1, mem_addr=line address + 4*cnt.
  - Each imem mem_ready stores the beat into the line buffer at word cnt, then cnt+1 and addr+4.
  - On the last beat (cnt = 2**width-1): write tag and data to the victim way, set its valid bit, advance the RR pointer modulo ways, mem_valid=0, go to UPDATE.
- UPDATE: one cycle. mem_ready=1, rdata=line buffer[word]; go to HIT.
- LOAD: mem_valid=1 at the original address.
  - On imem mem_ready: forward rdata, mem_ready=1 in the same cycle, mem_valid=0, go to HIT. Nothing is allocated.
- mem_ready is a single-cycle pulse; rdata is only meaningful when mem_ready=1.
- Reset mid-refill: the state machine returns to HIT, the partial line is discarded, and no valid bit is set.
- Counters wrap modulo their width: cnt over width bits, RR pointer over log2(ways) bits with a minimum of 1 bit.
- A fence while the cache is empty still responds with the 1-cycle ready.
- A request to the last word below itim_top is cacheable; a request at itim_top is bypassed.

Test Plan:
- ways=2, depth=2, width=2, base=0, top=0x1000. Fetch 0x0000 cold -> imem beats at 0x0000, 0x0004, 0x0008, 0x000C; ready with word0 in the UPDATE cycle. Refetch 0x0008 -> ready 1 cycle after the request with the third beat's data and no imem_in.mem_valid.
- Fill 0x0000 then 0x0040 (same set 0) -> both hit afterwards. Fetch 0x0080 -> evicts way0 (RR=0). 0x0040 still hits; 0x0000 misses.
- Fetch 0x2000 (outside the window) -> single imem read at 0x2000, rdata forwarded with ready in the same cycle as imem mem_ready. A second fetch of 0x2000 goes to imem again.
- Fill 3 lines, issue fence -> ready=1, rdata=0 one cycle later. Refetching any of the lines produces a full 4-beat refill.
- Assert rst=0 after the second refill beat -> imem mem_valid drops asynchronously. After release, a fetch of the same address produces a full 4-beat refill starting at beat 0.
- Fetch 0x0FFC -> cached via refill from 0x0FF0. Fetch 0x1000 -> bypass LOAD path.
